// File: rtl/top4_merge_if.sv
// Handshake bundle for top4_merge: tuple input stream, frame-result output stream, sticky error flag.
// The slave modport is the merge block's view, the master modport is the producer/consumer side.
interface top4_merge_if #(
  parameter int BITS  = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [BITS-1:0]  in_a;
  logic [BITS-1:0]  in_b;
  logic [BITS-1:0]  in_c;
  logic [BITS-1:0]  in_d;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [BITS-1:0]  out_a;
  logic [BITS-1:0]  out_b;
  logic [BITS-1:0]  out_c;
  logic [BITS-1:0]  out_d;
  logic [CNT_W-1:0] out_count;
  logic             err_unsorted;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, in_last, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, out_d, out_count, err_unsorted
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, in_last, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, out_d, out_count, err_unsorted
  );
endinterface

// File: rtl/top4_merge.sv
// Running top-4 over a frame of descending 4-tuples, one merge comparison per cycle; 5 cycles per tuple.
// in_ready only in IDLE; the frame result is held in DONE until out_ready, with no combinational path from it.
module top4_merge #(
  parameter int BITS  = 8,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  top4_merge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MERGE, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [BITS-1:0]  best  [4];
  logic [BITS-1:0]  new_v [4];
  logic [BITS-1:0]  res   [4];
  logic [1:0]       i;
  logic [1:0]       j;
  logic [1:0]       k;
  logic             last_q;
  logic [CNT_W-1:0] count;
  logic             err_q;

  logic             accept;
  logic             sorted;
  logic             take_best;
  logic [BITS-1:0]  pick;

  assign accept    = bus.in_valid && bus.in_ready;
  assign sorted    = (bus.in_a >= bus.in_b) && (bus.in_b >= bus.in_c) && (bus.in_c >= bus.in_d);
  // Ties favour the stored entry so equal values keep their existing order.
  assign take_best = best[i] >= new_v[j];
  assign pick      = take_best ? best[i] : new_v[j];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MERGE;
      MERGE:   if (k == 2'd3) state_nxt = last_q ? DONE : IDLE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        best[n]  <= '0;
        new_v[n] <= '0;
        res[n]   <= '0;
      end
      i      <= '0;
      j      <= '0;
      k      <= '0;
      last_q <= 1'b0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          new_v[0] <= bus.in_a;
          new_v[1] <= bus.in_b;
          new_v[2] <= bus.in_c;
          new_v[3] <= bus.in_d;
          last_q   <= bus.in_last;
          if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
          i <= '0;
          j <= '0;
          k <= '0;
          if (!sorted) err_q <= 1'b1;
        end
        MERGE: begin
          res[k] <= pick;
          if (take_best) i <= i + 2'd1;
          else           j <= j + 2'd1;
          k <= k + 2'd1;
          // Final step commits the merged list, taking this cycle's pick directly.
          if (k == 2'd3) begin
            best[0] <= res[0];
            best[1] <= res[1];
            best[2] <= res[2];
            best[3] <= pick;
          end
        end
        DONE: if (bus.out_ready) begin
          for (int n = 0; n < 4; n++) best[n] <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

  // rst_n gating keeps in_ready low throughout reset even though the FSM already sits in IDLE.
  assign bus.in_ready     = (state == IDLE) && rst_n;
  assign bus.out_valid    = (state == DONE);
  assign bus.out_a        = best[0];
  assign bus.out_b        = best[1];
  assign bus.out_c        = best[2];
  assign bus.out_d        = best[3];
  assign bus.out_count    = count;
  assign bus.err_unsorted = err_q;
endmodule

// File: tb/tb_top4_merge.sv
// Scoreboard bench for top4_merge: directed frames queue hand-computed results, a monitor pops them on each output handshake.
module tb_top4_merge;
  localparam int BITS  = 8;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [7:0]  d;
    logic [15:0] cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  top4_merge_if #(.BITS(BITS), .CNT_W(CNT_W)) bus();

  top4_merge #(.BITS(BITS), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    res_t got;
    res_t e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got = {bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_count};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=no_output", got);
      end else begin
        e = exp_q.pop_front();
        check("frame_result", 64'(got), 64'(e));
      end
    end
  end

  task automatic send(input logic [7:0] a, b, c, d, input logic last, output int at);
    int  n  = 0;
    bit  ok = 0;
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    at = -1;
    while (n < 200 && !ok) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1;
      n++;
    end
    if (ok) begin
      @(posedge clk);
      #1;
      at = cyc;
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (n < 100 && bus.out_valid !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout actual=0 required=1");
    end
  endtask

  task automatic drain();
    int n  = 0;
    bit ok = 0;
    while (n < 200 && !ok) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.in_ready === 1'b1) ok = 1;
      n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=pending_%0d required=pending_0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta;
    int tb;
    int sent;
    int flen;
    bit ok;
    logic [7:0] v [4];
    logic [7:0] m [4];
    logic [7:0] t;
    logic [7:0] x;
    int mcnt;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_outputs", {bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_count}, 64'd0);
    check("rst_err", 64'(bus.err_unsorted), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);

    // Single-tuple frame with latency checks
    bus.out_ready = 1'b1;
    exp_q.push_back('{8'd200, 8'd150, 8'd100, 8'd50, 16'd1});
    send(8'd200, 8'd150, 8'd100, 8'd50, 1'b1, ta);
    ok = 1;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) ok = 0;
    end
    check("single_busy_t0_t3", 64'(ok), 64'd1);
    @(negedge clk);
    check("single_valid_t4", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    check("single_ready_t5", {bus.out_valid, bus.in_ready}, 64'b01);
    @(posedge clk);
    #1;

    // Two-tuple frame and accept spacing
    exp_q.push_back('{8'd200, 8'd180, 8'd160, 8'd150, 16'd2});
    send(8'd200, 8'd150, 8'd100, 8'd50, 1'b0, ta);
    send(8'd180, 8'd160, 8'd10, 8'd5, 1'b1, tb);
    check("accept_spacing", 64'(tb - ta), 64'd5);
    drain();

    // Ties with held output under backpressure
    bus.out_ready = 1'b0;
    exp_q.push_back('{8'd100, 8'd100, 8'd100, 8'd100, 16'd2});
    send(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, ta);
    send(8'd100, 8'd90, 8'd90, 8'd0, 1'b1, tb);
    wait_out();
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_count} !== {32'h64646464, 16'd2})
        ok = 0;
    end
    check("bp_hold_stable", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_release", {bus.out_valid, bus.in_ready}, 64'b01);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    exp_q.push_back('{8'd7, 8'd6, 8'd5, 8'd4, 16'd1});
    send(8'd7, 8'd6, 8'd5, 8'd4, 1'b1, ta);
    drain();

    // Unsorted tuple: sticky flag, positional merge
    check("err_clear_before", 64'(bus.err_unsorted), 64'd0);
    exp_q.push_back('{8'd10, 8'd20, 8'd30, 8'd40, 16'd1});
    send(8'd10, 8'd20, 8'd30, 8'd40, 1'b1, ta);
    @(negedge clk);
    check("err_set", 64'(bus.err_unsorted), 64'd1);
    drain();
    exp_q.push_back('{8'd5, 8'd4, 8'd3, 8'd2, 16'd1});
    send(8'd5, 8'd4, 8'd3, 8'd2, 1'b1, ta);
    drain();
    check("err_sticky", 64'(bus.err_unsorted), 64'd1);

    // Reset in the middle of a merge aborts the frame
    send(8'd50, 8'd40, 8'd30, 8'd20, 1'b1, ta);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("abort_rst_outputs", {bus.out_valid, bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_count}, 64'd0);
    check("abort_err_cleared", 64'(bus.err_unsorted), 64'd0);
    rst_n = 1'b1;
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) ok = 0;
    end
    check("abort_no_output", 64'(ok), 64'd1);
    @(posedge clk);
    #1;

    // Random pre-sorted tuples against a reference top-4
    sent = 0;
    while (sent < 1000) begin
      flen = $urandom_range(1, 8);
      if (flen > 1000 - sent) flen = 1000 - sent;
      for (int p = 0; p < 4; p++) m[p] = '0;
      mcnt = 0;
      for (int f = 0; f < flen; f++) begin
        for (int p = 0; p < 4; p++) v[p] = 8'($urandom_range(0, 255));
        for (int p = 0; p < 3; p++)
          for (int q = 0; q < 3 - p; q++)
            if (v[q] < v[q+1]) begin
              t = v[q]; v[q] = v[q+1]; v[q+1] = t;
            end
        for (int p = 0; p < 4; p++) begin
          x = v[p];
          for (int r = 0; r < 4; r++)
            if (x > m[r]) begin
              t = m[r]; m[r] = x; x = t;
            end
        end
        mcnt++;
        if (f == flen - 1)
          exp_q.push_back('{m[0], m[1], m[2], m[3], 16'(mcnt)});
        send(v[0], v[1], v[2], v[3], (f == flen - 1), ta);
        sent++;
      end
    end
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/top4_merge.md
# top4_merge

Sequential stage directly downstream of `cas4`. It accepts a stream of descending-sorted 4-tuples (`cas4` outputs) and keeps a running top-4 across a frame of tuples by merging each tuple into stored state, one comparison per cycle. At end of frame it presents the four largest values seen and the tuple count over a valid/ready handshake, then clears for the next frame.

## Interface
- `BITS`, 8, width of each value (unsigned)
- `CNT_W`, 16, width of tuple counter
---
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input tuple valid
- `in_ready`  out  1  block can accept tuple
- `in_a`, `in_b`, `in_c`, `in_d`  in  BITS each  tuple, expected `in_a>=in_b>=in_c>=in_d`
- `in_last`  in  1  tuple is last of frame; sampled with tuple
- `out_valid`  out  1  frame result valid
- `out_ready`  in  1  consumer accepts result
- `out_a`, `out_b`, `out_c`, `out_d`  out  BITS each  frame top-4, descending
- `out_count`  out  CNT_W  tuples accepted in frame, saturating
- `err_unsorted`  out  1  sticky: some accepted tuple was not descending

## Operation
- State: `best[0..3]` (descending), `new[0..3]`, `res[0..3]`, indices `i`, `j`, step `k` (2 bits each), `last_q`, `count`, FSM.
- FSM states: IDLE, MERGE, DONE.
- IDLE: `in_ready=1`. On `in_valid&in_ready`: latch tuple into `new`, latch `in_last` into `last_q`, `count<=count+1` (saturating at 2^CNT_W-1), clear `i`, `j`, `k`, go to MERGE.
- Sort check at acceptance: if `!(in_a>=in_b && in_b>=in_c && in_c>=in_d)`, set `err_unsorted` (cleared only by reset). The tuple is still merged as given, positionally.
- MERGE, each cycle: if `best[i] >= new[j]`, `res[k]<=best[i]`, `i++`; else `res[k]<=new[j]`, `j++`. Ties take from `best`. `k++`.
- At step `k==3`: write the 4-entry merged result, including the step-3 value, into `best`. Go to DONE if `last_q`, otherwise to IDLE.
- `i+j==k<=3` always, so neither index overflows.
- DONE: `out_valid=1`. `out_a..d=best[0..3]`, `out_count=count`. Hold while `out_ready=0`. On `out_valid&out_ready`: `best<=0`, `count<=0`, go to IDLE.
- `out_a..d` and `out_count` continuously reflect `best`/`count` in all states. They are meaningful only while `out_valid`.
- `in_ready=0` in MERGE and DONE. Input is not consumed there; the upstream holds it.
- Empty slots are 0 (unsigned minimum). A frame of one tuple outputs that tuple.

## Timing
- Reset (async assert, sync-released by the system): state IDLE. `best`, `new`, `res`, `count`, indices = 0. `err_unsorted=0`, `out_valid=0`, `out_*=0`, `out_count=0`.
- `in_ready` is low while `rst_n=0`, and high in the first cycle after release.
- Reset during MERGE or DONE aborts the frame with no output.
- Accept at edge t. Merge steps occur on edges t+1..t+4. `best` is updated at t+4.
  - Non-last tuple: `in_ready` is high again after t+4; the earliest next accept is t+5. Sustained rate is 1 tuple per 5 cycles.
  - Last tuple: `out_valid` is high after edge t+4. If `out_ready=1`, `out_valid` drops and `in_ready` rises after edge t+5.
- `out_valid` and the outputs are registered with no combinational path from `out_ready`. `in_ready` depends only on FSM state.
- `err_unsorted` rises after the accepting edge.

## Test plan
- Reset: hold `rst_n=0` 3 cycles → all outputs 0, `in_ready=0`. Release → `in_ready=1` next cycle.
- Single-tuple frame (200,150,100,50,last=1), accepted at edge t:
  - `out_valid` rises after t+4 with 200,150,100,50, `out_count=1`.
  - With `out_ready=1`, `in_ready` returns after t+5.
- Two-tuple frame (200,150,100,50) then (180,160,10,5,last):
  - Output 200,180,160,150, `count=2`.
  - Second accept no earlier than 5 edges after the first.
- Ties plus backpressure: frame (100,100,100,100),(100,90,90,0,last) with `out_ready=0` for 10 cycles:
  - Output 100,100,100,100 held stable with `out_valid=1` and `in_ready=0`.
  - Released after `out_ready` pulses.
  - Next frame (7,6,5,4,last) outputs 7,6,5,4, confirming `best` cleared.
- Unsorted input (10,20,30,40,last):
  - `err_unsorted=1` after accept and stays 1 through later frames until reset.
  - Output is the positional merge against zeros: 10,20,30,40.
- Reset mid-MERGE: assert `rst_n` low 2 cycles after accepting a last tuple → `out_valid` never rises, all state 0. Also run 1000 random pre-sorted tuples (frames of 1–8) against a reference top-4 model.
